filter_sched: RTL
=================

// Module: filter_sched
// PURPOSE
// - Time-shares one IIR filter engine (start/done handshake) between NCH channels (e.g. low-pass, high-pass).
// - Each channel raises a sample strobe from its PWM period; the scheduler arbitrates round-robin and fetches the next ROM sample.
// - It issues the sample plus per-channel coefficients and history to the engine, and writes back the result.
// - Sits between rom, the shared filter engine and the per-channel pwm blocks in the top level.
// PARAMETERS
// - NCH      2      number of channels (1..4)
// - W        32     datapath/coefficient width
// - AW       15     ROM address width
// - DW       23     ROM data width (zero-extended to W)
// - TIMEOUT  64     max WAIT cycles; used only with FILTER_SCHED_TIMEOUT_EN
// PORTS
// - clk         in   1         system clock
// - rst         in   1         synchronous active-high reset
// - filter_rst  in   1         sync clear of history + addresses; coefficients kept
// - req         in   NCH       per-channel sample strobe, 1-cycle pulse
// - cfg_we      in   1         coefficient write enable
// - cfg_ch      in   2         coefficient channel index
// - cfg_sel     in   2         0=c0, 1=c1, 2=c2 (3 ignored)
// - cfg_data    in   W         coefficient value
// - rom_addr    out  AW        ROM address; ROM read latency is 1 clk
// - rom_data    in   DW        ROM sample
// - eng_start   out  1         1-cycle start pulse to the engine
// - eng_x       out  W         current sample
// - eng_xprev   out  W         previous sample
// - eng_yprev   out  W         previous output
// - eng_c0      out  W         coefficient 0
// - eng_c1      out  W         coefficient 1
// - eng_c2      out  W         coefficient 2
// - eng_done    in   1         engine result valid, 1-cycle pulse
// - eng_y       in   W         engine result
// - y           out  NCH*W     per-channel output register; channel i = y[i*W +: W]
// - y_valid     out  NCH       1-cycle pulse when y[i] updates
// - overrun     out  NCH       sticky: req arrived while the same channel was already pending
// - busy        out  1         FSM not in IDLE
// BEHAVIOUR
// - Reset: all outputs 0, FSM=IDLE, pending=0, rr pointer=0, coefficients=0, addresses=0, history=0.
// - pending[i] is set on req[i].
//   - req[i] while pending[i]=1 -> overrun[i]=1 (sticky until rst); the request is merged.
//   - req[i] in the same cycle pending[i] is cleared by grant -> pending[i] stays 1.
// - Arbitration in IDLE: grant the lowest pending index >= rr (wrapping); rr <= grant+1 mod NCH.
// - FSM:
//   - IDLE -> FETCH on any pending; rom_addr <= addr[g].
//   - FETCH (1 clk, ROM latency) -> ISSUE.
//   - ISSUE: eng_start=1 for one cycle; eng_x={0,rom_data}; history/coefficients of g driven and held stable through WAIT -> WAIT.
//   - WAIT -> WB on eng_done.
//   - WB: y[g]<=eng_y; yprev[g]<=eng_y; xprev[g]<=eng_x; addr[g]<=addr[g]+1 (wraps 2^AW-1 -> 0); y_valid[g]=1 -> IDLE.
// - Latency req -> y_valid: 4 + engine latency cycles when idle (req->IDLE grant 1, FETCH 1, ISSUE 1, WB 1).
// - eng_done outside WAIT is ignored.
// - cfg writes apply any cycle and never stall.
//   - A write to the granted channel during FETCH/ISSUE/WAIT takes effect on its next issue; engine inputs are latched at ISSUE.
// - filter_rst:
//   - Clears xprev, yprev, addr and pending for all channels.
//   - An in-flight operation is discarded: the FSM returns to IDLE and no y_valid is issued.
//   - y registers are kept.
// - rst mid-operation: FSM -> IDLE next cycle, eng_start low; a late eng_done is ignored.
// CONFIGURATION
// - FILTER_SCHED_TIMEOUT_EN defined: a WAIT counter aborts after TIMEOUT cycles without eng_done.
//   - On abort: output timeout_err (1 bit, sticky) is set; y, history and addr are unchanged; pending is cleared; FSM -> IDLE.
// - Not defined: WAIT is unbounded; no timeout_err port; no counter logic.
// TESTING
// - Single request: program ch0 c0=0x3F5, req[0] pulse, ROM[0]=0x000100, engine returns 0x1234 after 3 clk
//   -> eng_x=0x100, y_valid[0] 7 clk after req, y[0]=0x1234, rom_addr for ch0 next = 1.
// - Round robin: req=2'b11 in one cycle -> ch0 served first, then ch1.
//   - Next simultaneous req=2'b11 while rr=0 -> ch0, ch1 again; with rr=1 -> ch1 first.
// - Overrun: req[1] twice while ch1 is pending -> overrun=2'b10, exactly one y_valid[1].
// - Address wrap: AW=4, 16 ch0 requests -> rom_addr sequence 0..15, then 0.
// - filter_rst during WAIT: no y_valid; next op sees xprev=0, yprev=0, addr=0; coefficients unchanged.
// - Timeout (macro on, TIMEOUT=8): engine never asserts done -> timeout_err=1 at WAIT cycle 8, busy=0 next cycle, y unchanged.

Source files
------------

// File: rtl/filter_sched.sv
// filter_sched: round-robin scheduler sharing one IIR filter engine across NCH channels.
// Defining FILTER_SCHED_TIMEOUT_EN bounds WAIT to TIMEOUT cycles and adds a sticky timeout_err.
module filter_sched #(
    parameter int NCH     = 2,
    parameter int W       = 32,
    parameter int AW      = 15,
    parameter int DW      = 23,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             filter_rst,
    input  logic [NCH-1:0]   req,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_ch,
    input  logic [1:0]       cfg_sel,
    input  logic [W-1:0]     cfg_data,
    output logic [AW-1:0]    rom_addr,
    input  logic [DW-1:0]    rom_data,
    output logic             eng_start,
    output logic [W-1:0]     eng_x,
    output logic [W-1:0]     eng_xprev,
    output logic [W-1:0]     eng_yprev,
    output logic [W-1:0]     eng_c0,
    output logic [W-1:0]     eng_c1,
    output logic [W-1:0]     eng_c2,
    input  logic             eng_done,
    input  logic [W-1:0]     eng_y,
    output logic [NCH*W-1:0] y,
    output logic [NCH-1:0]   y_valid,
    output logic [NCH-1:0]   overrun,
`ifdef FILTER_SCHED_TIMEOUT_EN
    output logic             timeout_err,
`endif
    output logic             busy
);
    localparam int CW = NCH > 1 ? $clog2(NCH) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, WB} state_t;

    state_t                 state;
    logic [CW-1:0]          g, rr, gnt;
    logic [NCH-1:0]         pending, clr;
    logic [NCH-1:0][W-1:0]  c0, c1, c2, xp, yp, y_r;
    logic [NCH-1:0][AW-1:0] addr;
    logic [W-1:0]           x_q;
`ifdef FILTER_SCHED_TIMEOUT_EN
    localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0]          cnt;
`endif

    if (NCH < 1 || NCH > 4 || TIMEOUT < 1) begin : g_bad_param
        $error("filter_sched: unsupported parameters");
    end

    assign y     = y_r;
    assign busy  = state != IDLE;
    // ROM data is only valid during ISSUE; afterwards the captured copy keeps eng_x stable
    assign eng_x = state == ISSUE ? W'(rom_data) : x_q;
    assign clr   = state == IDLE ? NCH'(1) << gnt : '0;

    // descending scan so the lowest offset from rr wins
    always_comb begin
        gnt = '0;
        for (int k = NCH - 1; k >= 0; k--)
            if (pending[CW'((int'(rr) + k) % NCH)]) gnt = CW'((int'(rr) + k) % NCH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c0 <= '0;
            c1 <= '0;
            c2 <= '0;
        end else if (cfg_we && int'(cfg_ch) < NCH) begin
            if (cfg_sel == 2'd0) c0[cfg_ch[CW-1:0]] <= cfg_data;
            if (cfg_sel == 2'd1) c1[cfg_ch[CW-1:0]] <= cfg_data;
            if (cfg_sel == 2'd2) c2[cfg_ch[CW-1:0]] <= cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            g         <= '0;
            rr        <= '0;
            pending   <= '0;
            overrun   <= '0;
            rom_addr  <= '0;
            eng_start <= 1'b0;
            eng_xprev <= '0;
            eng_yprev <= '0;
            eng_c0    <= '0;
            eng_c1    <= '0;
            eng_c2    <= '0;
            x_q       <= '0;
            xp        <= '0;
            yp        <= '0;
            addr      <= '0;
            y_r       <= '0;
            y_valid   <= '0;
`ifdef FILTER_SCHED_TIMEOUT_EN
            cnt         <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            overrun   <= overrun | (req & pending & ~clr);
            pending   <= filter_rst ? '0 : (pending & ~clr) | req;
            eng_start <= 1'b0;
            y_valid   <= '0;
            if (filter_rst) begin
                state <= IDLE;
                xp    <= '0;
                yp    <= '0;
                addr  <= '0;
            end else begin
                case (state)
                    IDLE: if (|pending) begin
                        g        <= gnt;
                        rr       <= CW'((int'(gnt) + 1) % NCH);
                        rom_addr <= addr[gnt];
                        state    <= FETCH;
                    end
                    FETCH: begin
                        eng_start <= 1'b1;
                        eng_xprev <= xp[g];
                        eng_yprev <= yp[g];
                        eng_c0    <= c0[g];
                        eng_c1    <= c1[g];
                        eng_c2    <= c2[g];
                        state     <= ISSUE;
                    end
                    ISSUE: begin
                        x_q   <= W'(rom_data);
`ifdef FILTER_SCHED_TIMEOUT_EN
                        cnt   <= '0;
`endif
                        state <= WAIT;
                    end
                    WAIT: if (eng_done) begin
                        y_r[g]     <= eng_y;
                        yp[g]      <= eng_y;
                        xp[g]      <= x_q;
                        addr[g]    <= addr[g] + AW'(1);
                        y_valid[g] <= 1'b1;
                        state      <= WB;
                    end
`ifdef FILTER_SCHED_TIMEOUT_EN
                    else if (cnt == TW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        pending     <= '0;
                        state       <= IDLE;
                    end else cnt <= cnt + TW'(1);
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
